ofdm_puncture: RTL and testbench
================================

// Module: ofdm_puncture
// PURPOSE
//  Puncturer / serializer directly downstream of the K=7 rate-1/2 convolutional encoder.
//  Takes coded pairs {B,A} and emits them one bit per beat, A first.
//  Drops bits per the 802.11a pattern selected by the RATE field: 1/2, 2/3 or 3/4.
//  Feeds the interleaver.
//  SIGNAL-field pairs (sig_flag=1) are always passed at rate 1/2.
// PARAMETERS
//  RATE_RST   4'b1011  reset value of pct_dout_rate_con
//  SIG_CLR    1        1: every accepted pair with sig_flag=1 clears the puncture phase to 0
// PORTS
//  clk                 in   1  clock
//  rst_n               in   1  asynchronous, active-low reset
//  pct_din             in   2  coded pair; [0]=A (output 0), [1]=B (output 1)
//  pct_din_vld         in   1  pair valid
//  pct_din_rdy         out  1  puncturer can accept a pair this cycle
//  pct_din_sig_flag    in   1  pair belongs to the SIGNAL field
//  pct_din_rate_con    in   4  802.11a RATE bits, travel with the pair
//  pct_dout            out  1  serial punctured bit
//  pct_dout_vld        out  1  pct_dout valid
//  pct_dout_rdy        in   1  downstream ready
//  pct_dout_sig_flag   out  1  sig_flag of the pair the current bit came from
//  pct_dout_rate_con   out  4  rate_con of the pair the current bit came from
// BEHAVIOUR
//  Reset (async): cnt=0, q=0, phase=0.
//    pct_dout=0, pct_dout_vld=0, pct_dout_sig_flag=0, pct_dout_rate_con=RATE_RST.
//  State:
//    q[1:0]   holding shift register
//    cnt      bits pending, 0..2
//    phase    puncture phase, 0..2
//  Outputs:
//    pct_dout     = q[0]
//    pct_dout_vld = (cnt != 0)
//    All outputs are registered.
//  Handshake:
//    fire_out = pct_dout_vld & pct_dout_rdy
//    pct_din_rdy = (cnt==0) | (cnt==1 & pct_dout_rdy)   (combinational)
//    accept = pct_din_vld & pct_din_rdy
//  Mode select:
//    sig_flag=1                   -> R12
//    rate_con 1101/0101/1001      -> R12
//    rate_con 0001                -> R23
//    rate_con 1111/0111/1011/0011 -> R34
//    any other code               -> R12
//  Keep table (per accepted pair):
//    R12: keep A,B; phase stays 0.
//    R23: ph0 keep A,B; ph1 keep A. Phase cycles 0,1.
//    R34: ph0 keep A,B; ph1 keep A; ph2 keep B. Phase cycles 0,1,2.
//    R34 result: A0 B0 A1 B2 per 3 pairs. R23 result: A0 B0 A1 per 2 pairs.
//  On accept:
//    keep A,B -> q={B,A}, cnt=2
//    keep A   -> q[0]=A, cnt=1
//    keep B   -> q[0]=B, cnt=1
//    Latch sig_flag and rate_con into the pct_dout_* registers.
//    Advance phase; if sig_flag=1 and SIG_CLR, set phase to 0 instead.
//  On fire_out without accept:
//    q = q>>1, cnt = cnt-1
//    sig/rate outputs hold.
//  Simultaneous fire_out of the last bit and accept:
//    Load takes priority; no bubble, no loss.
//  Latency: pair accepted at edge N -> first bit valid after edge N (cycle N+1).
//  Throughput:
//    R12 accepts 1 pair per 2 cycles.
//    A 1-bit pair occupies 1 cycle.
//  Back-pressure (pct_dout_rdy=0):
//    pct_dout, pct_dout_vld and side-band outputs hold stable.
//    pct_din_rdy=0 while cnt>=1.
//  Phase is not affected by stalls; it advances only on accept.
//  Reset mid-packet discards pending bits and phase immediately.
// TESTING
//  T1 sig_flag=1, rate 1011, pairs 2'b10 then 2'b01, rdy=1
//     -> dout 0,1,1,0; din_rdy 1,0,1,0.
//  T2 sig pair, then rate 1011 sig=0, six pairs with A=1,B=0
//     -> 8 bits 1,0,1,0,1,0,1,0; phase returns to 0.
//  T3 rate 0001, pairs A/B = 1/0,0/1,1/1,0/0
//     -> bits A0 B0 A1 A2 B2 A3 = 1,0,0,1,1,0.
//  T4 cnt=2 and dout_rdy=0 for 5 cycles
//     -> dout/vld/sig/rate constant, din_rdy=0; both bits later delivered in order.
//  T5 rst_n low mid-R34 group
//     -> outputs at reset values; next data pair is punctured from phase 0.
//  T6 rate 0000, sig=0, 4 random pairs
//     -> all 8 bits out (rate 1/2); random valid/ready on both sides matches golden model.

Source files
------------

// File: rtl/ofdm_puncture_if.sv
// Bundle of the upstream (encoder) and downstream (interleaver) handshake signals of the puncturer.
// The slave modport is the puncturer's own view; master is the view of whoever drives it.
interface ofdm_puncture_if;
  logic [1:0] pct_din;
  logic       pct_din_vld;
  logic       pct_din_rdy;
  logic       pct_din_sig_flag;
  logic [3:0] pct_din_rate_con;
  logic       pct_dout;
  logic       pct_dout_vld;
  logic       pct_dout_rdy;
  logic       pct_dout_sig_flag;
  logic [3:0] pct_dout_rate_con;

  modport slave (
    input  pct_din, pct_din_vld, pct_din_sig_flag, pct_din_rate_con, pct_dout_rdy,
    output pct_din_rdy, pct_dout, pct_dout_vld, pct_dout_sig_flag, pct_dout_rate_con
  );

  modport master (
    output pct_din, pct_din_vld, pct_din_sig_flag, pct_din_rate_con, pct_dout_rdy,
    input  pct_din_rdy, pct_dout, pct_dout_vld, pct_dout_sig_flag, pct_dout_rate_con
  );
endinterface

// File: rtl/ofdm_puncture.sv
// 802.11a puncturer/serializer: takes coded pairs {B,A} from the K=7 encoder and emits the kept
// bits one per beat, A first, with the rate 1/2, 2/3 or 3/4 pattern selected by the RATE field.
module ofdm_puncture #(
  parameter logic [3:0] RATE_RST = 4'b1011,
  parameter bit         SIG_CLR  = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  ofdm_puncture_if.slave  pct
);

  typedef enum logic [1:0] {
    MODE_R12 = 2'd0,
    MODE_R23 = 2'd1,
    MODE_R34 = 2'd2
  } mode_t;

  logic [1:0] r_q;
  logic [1:0] r_cnt;
  logic [1:0] r_phase;
  logic       r_vld;
  logic       r_sig;
  logic [3:0] r_rate;

  mode_t      w_mode;
  logic       w_keepA;
  logic       w_keepB;
  logic [1:0] w_phaseNext;
  logic [1:0] w_qNext;
  logic [1:0] w_cntNext;
  logic       w_fire;
  logic       w_dinRdy;
  logic       w_accept;

  assign w_fire   = r_vld & pct.pct_dout_rdy;
  assign w_dinRdy = (r_cnt == 2'd0) | ((r_cnt == 2'd1) & pct.pct_dout_rdy);
  assign w_accept = pct.pct_din_vld & w_dinRdy;

  // SIGNAL-field pairs always go out at rate 1/2, whatever RATE says.
  always_comb begin
    w_mode = MODE_R12;
    if (!pct.pct_din_sig_flag) begin
      case (pct.pct_din_rate_con)
        4'b0001:                            w_mode = MODE_R23;
        4'b1111, 4'b0111, 4'b1011, 4'b0011: w_mode = MODE_R34;
        default:                            w_mode = MODE_R12;
      endcase
    end
  end

  always_comb begin
    w_keepA     = 1'b1;
    w_keepB     = 1'b1;
    w_phaseNext = 2'd0;
    case (w_mode)
      MODE_R23: begin
        if (r_phase != 2'd0) w_keepB = 1'b0;
        w_phaseNext = (r_phase == 2'd0) ? 2'd1 : 2'd0;
      end
      MODE_R34: begin
        case (r_phase)
          2'd0:    w_phaseNext = 2'd1;
          2'd1: begin
            w_keepB     = 1'b0;
            w_phaseNext = 2'd2;
          end
          default: begin
            w_keepA     = 1'b0;
            w_phaseNext = 2'd0;
          end
        endcase
      end
      default: w_phaseNext = 2'd0;
    endcase
    // Without SIG_CLR a SIGNAL pair leaves the data puncture phase untouched.
    if (pct.pct_din_sig_flag && !SIG_CLR) w_phaseNext = r_phase;
  end

  // A load wins over a shift, so the last pending bit and a new pair can share one edge.
  always_comb begin
    w_qNext   = r_q;
    w_cntNext = r_cnt;
    if (w_accept) begin
      if (w_keepA && w_keepB) begin
        w_qNext   = pct.pct_din;
        w_cntNext = 2'd2;
      end else if (w_keepA) begin
        w_qNext   = {1'b0, pct.pct_din[0]};
        w_cntNext = 2'd1;
      end else begin
        w_qNext   = {1'b0, pct.pct_din[1]};
        w_cntNext = 2'd1;
      end
    end else if (w_fire) begin
      w_qNext   = {1'b0, r_q[1]};
      w_cntNext = r_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= 2'b00;
      r_cnt   <= 2'd0;
      r_phase <= 2'd0;
      r_vld   <= 1'b0;
      r_sig   <= 1'b0;
      r_rate  <= RATE_RST;
    end else begin
      r_q   <= w_qNext;
      r_cnt <= w_cntNext;
      r_vld <= (w_cntNext != 2'd0);
      if (w_accept) begin
        r_phase <= w_phaseNext;
        r_sig   <= pct.pct_din_sig_flag;
        r_rate  <= pct.pct_din_rate_con;
      end
    end
  end

  assign pct.pct_din_rdy       = w_dinRdy;
  assign pct.pct_dout          = r_q[0];
  assign pct.pct_dout_vld      = r_vld;
  assign pct.pct_dout_sig_flag = r_sig;
  assign pct.pct_dout_rate_con = r_rate;

endmodule

// File: tb/tb_ofdm_puncture.sv
// Directed bench for ofdm_puncture: a table of pairs with hand-computed kept bits, streamed once
// back-to-back and once with random gaps/back-pressure, plus hand sequences for timing corners.
module tb_ofdm_puncture;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ofdm_puncture_if bus();

  ofdm_puncture #(.RATE_RST(4'b1011), .SIG_CLR(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pct   (bus)
  );

  // exp holds the kept bits in output order: exp[0] first, exp[1] second (only if nExp==2).
  typedef struct {
    logic [1:0] din;
    logic       sig;
    logic [3:0] rate;
    int         nExp;
    logic [1:0] exp;
  } vec_t;

  typedef struct {
    logic       b;
    logic       sig;
    logic [3:0] rate;
  } expBit_t;

  localparam int NVEC = 32;
  vec_t    vecs[NVEC];
  expBit_t sbQ[$];
  expBit_t monE;
  int      total = 0;
  int      bad = 0;
  bit      sbOn = 1'b0;
  bit      randRdy = 1'b0;

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (randRdy) bus.pct_dout_rdy = 1'($urandom_range(0, 1));
    #1;
  endtask

  // Scoreboard side: every fired bit is matched against the next expected bit.
  always @(negedge clk) begin
    if (sbOn && bus.pct_dout_vld && bus.pct_dout_rdy) begin
      if (sbQ.size() == 0) begin
        checkOutput("extraBit", 1, 0);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("sbBit", int'(bus.pct_dout), int'(monE.b));
        checkOutput("sbSig", int'(bus.pct_dout_sig_flag), int'(monE.sig));
        checkOutput("sbRate", int'(bus.pct_dout_rate_con), int'(monE.rate));
      end
    end
  end

  task automatic applyStimulus(input bit randMode);
    bit acc;
    bit accepted;
    for (int i = 0; i < NVEC; i++)
      for (int k = 0; k < vecs[i].nExp; k++)
        sbQ.push_back('{vecs[i].exp[k], vecs[i].sig, vecs[i].rate});
    randRdy = randMode;
    sbOn = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      if (randMode) begin
        bus.pct_din_vld = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      bus.pct_din          = vecs[i].din;
      bus.pct_din_sig_flag = vecs[i].sig;
      bus.pct_din_rate_con = vecs[i].rate;
      bus.pct_din_vld      = 1'b1;
      accepted = 1'b0;
      for (int c = 0; c < 100 && !accepted; c++) begin
        acc = bus.pct_din_rdy;
        tick();
        accepted = acc;
      end
      if (!accepted) checkOutput("acceptTimeout", 0, 1);
      bus.pct_din_vld = 1'b0;
    end
    for (int c = 0; c < 300 && sbQ.size() != 0; c++) tick();
    checkOutput("sbDrained", sbQ.size(), 0);
    sbOn = 1'b0;
    sbQ.delete();
    randRdy = 1'b0;
    bus.pct_dout_rdy = 1'b1;
    tick();
  endtask

  initial begin
    vecs[0]  = '{2'b10, 1'b1, 4'b1011, 2, 2'b10};
    vecs[1]  = '{2'b01, 1'b1, 4'b1011, 2, 2'b01};
    vecs[2]  = '{2'b01, 1'b1, 4'b1011, 2, 2'b01};
    vecs[3]  = '{2'b01, 1'b0, 4'b1011, 2, 2'b01};
    vecs[4]  = '{2'b01, 1'b0, 4'b1011, 1, 2'b01};
    vecs[5]  = '{2'b01, 1'b0, 4'b1011, 1, 2'b00};
    vecs[6]  = '{2'b01, 1'b0, 4'b1011, 2, 2'b01};
    vecs[7]  = '{2'b01, 1'b0, 4'b1011, 1, 2'b01};
    vecs[8]  = '{2'b01, 1'b0, 4'b1011, 1, 2'b00};
    vecs[9]  = '{2'b01, 1'b0, 4'b0001, 2, 2'b01};
    vecs[10] = '{2'b10, 1'b0, 4'b0001, 1, 2'b00};
    vecs[11] = '{2'b11, 1'b0, 4'b0001, 2, 2'b11};
    vecs[12] = '{2'b00, 1'b0, 4'b0001, 1, 2'b00};
    vecs[13] = '{2'b11, 1'b0, 4'b0000, 2, 2'b11};
    vecs[14] = '{2'b10, 1'b0, 4'b0000, 2, 2'b10};
    vecs[15] = '{2'b00, 1'b0, 4'b0000, 2, 2'b00};
    vecs[16] = '{2'b01, 1'b0, 4'b0000, 2, 2'b01};
    vecs[17] = '{2'b10, 1'b0, 4'b1101, 2, 2'b10};
    vecs[18] = '{2'b11, 1'b0, 4'b0111, 2, 2'b11};
    vecs[19] = '{2'b10, 1'b0, 4'b0111, 1, 2'b00};
    vecs[20] = '{2'b01, 1'b0, 4'b0111, 1, 2'b00};
    vecs[21] = '{2'b10, 1'b0, 4'b0011, 2, 2'b10};
    vecs[22] = '{2'b11, 1'b1, 4'b0011, 2, 2'b11};
    vecs[23] = '{2'b01, 1'b0, 4'b0011, 2, 2'b01};
    vecs[24] = '{2'b10, 1'b0, 4'b0011, 1, 2'b00};
    vecs[25] = '{2'b10, 1'b0, 4'b0011, 1, 2'b01};
    vecs[26] = '{2'b10, 1'b0, 4'b1110, 2, 2'b10};
    vecs[27] = '{2'b01, 1'b0, 4'b1001, 2, 2'b01};
    vecs[28] = '{2'b11, 1'b0, 4'b1111, 2, 2'b11};
    vecs[29] = '{2'b01, 1'b0, 4'b1111, 1, 2'b01};
    vecs[30] = '{2'b10, 1'b0, 4'b1111, 1, 2'b01};
    vecs[31] = '{2'b11, 1'b0, 4'b1010, 2, 2'b11};

    bus.pct_din          = 2'b00;
    bus.pct_din_vld      = 1'b0;
    bus.pct_din_sig_flag = 1'b0;
    bus.pct_din_rate_con = 4'b0000;
    bus.pct_dout_rdy     = 1'b1;

    #12;
    checkOutput("rstVld", int'(bus.pct_dout_vld), 0);
    checkOutput("rstDout", int'(bus.pct_dout), 0);
    checkOutput("rstSig", int'(bus.pct_dout_sig_flag), 0);
    checkOutput("rstRate", int'(bus.pct_dout_rate_con), 11);
    checkOutput("rstDinRdy", int'(bus.pct_din_rdy), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // SIGNAL pairs back-to-back: din_rdy 1,0,1,0 and dout 0,1,1,0.
    $display("[TB] signal pair sequence");
    @(posedge clk); #1;
    bus.pct_din = 2'b10; bus.pct_din_sig_flag = 1'b1; bus.pct_din_rate_con = 4'b1011;
    bus.pct_din_vld = 1'b1;
    @(negedge clk);
    checkOutput("t1Rdy0", int'(bus.pct_din_rdy), 1);
    @(posedge clk); #1;
    bus.pct_din = 2'b01;
    @(negedge clk);
    checkOutput("t1Rdy1", int'(bus.pct_din_rdy), 0);
    checkOutput("t1Vld1", int'(bus.pct_dout_vld), 1);
    checkOutput("t1Dout1", int'(bus.pct_dout), 0);
    checkOutput("t1Sig1", int'(bus.pct_dout_sig_flag), 1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t1Rdy2", int'(bus.pct_din_rdy), 1);
    checkOutput("t1Dout2", int'(bus.pct_dout), 1);
    @(posedge clk); #1;
    bus.pct_din_vld = 1'b0;
    @(negedge clk);
    checkOutput("t1Rdy3", int'(bus.pct_din_rdy), 0);
    checkOutput("t1Dout3", int'(bus.pct_dout), 1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t1Vld4", int'(bus.pct_dout_vld), 1);
    checkOutput("t1Dout4", int'(bus.pct_dout), 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t1VldEnd", int'(bus.pct_dout_vld), 0);
    tick();

    $display("[TB] vector table, full rate");
    applyStimulus(1'b0);
    $display("[TB] vector table, random gaps and back-pressure");
    applyStimulus(1'b1);

    // Stall with two bits pending: everything holds, a waiting pair is not taken.
    $display("[TB] stall sequence");
    @(posedge clk); #1;
    bus.pct_dout_rdy = 1'b0;
    bus.pct_din = 2'b10; bus.pct_din_sig_flag = 1'b0; bus.pct_din_rate_con = 4'b0101;
    bus.pct_din_vld = 1'b1;
    @(negedge clk);
    checkOutput("t4RdyIdle", int'(bus.pct_din_rdy), 1);
    @(posedge clk); #1;
    bus.pct_din = 2'b11;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checkOutput("t4Dout", int'(bus.pct_dout), 0);
      checkOutput("t4Vld", int'(bus.pct_dout_vld), 1);
      checkOutput("t4Sig", int'(bus.pct_dout_sig_flag), 0);
      checkOutput("t4Rate", int'(bus.pct_dout_rate_con), 5);
      checkOutput("t4DinRdy", int'(bus.pct_din_rdy), 0);
    end
    @(posedge clk); #1;
    bus.pct_din_vld = 1'b0;
    bus.pct_dout_rdy = 1'b1;
    @(negedge clk);
    checkOutput("t4RelA", int'(bus.pct_dout), 0);
    checkOutput("t4RelVldA", int'(bus.pct_dout_vld), 1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t4RelB", int'(bus.pct_dout), 1);
    checkOutput("t4RelVldB", int'(bus.pct_dout_vld), 1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t4RelEnd", int'(bus.pct_dout_vld), 0);

    // Reset in the middle of a 3/4 group, then the next pair must start again at phase 0.
    $display("[TB] reset mid-group sequence");
    @(posedge clk); #1;
    bus.pct_din = 2'b11; bus.pct_din_sig_flag = 1'b0; bus.pct_din_rate_con = 4'b1111;
    bus.pct_din_vld = 1'b1;
    @(posedge clk); #1;
    bus.pct_din_vld = 1'b0;
    @(negedge clk);
    checkOutput("t5PreVld", int'(bus.pct_dout_vld), 1);
    checkOutput("t5PreDout", int'(bus.pct_dout), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5RstVld", int'(bus.pct_dout_vld), 0);
    checkOutput("t5RstDout", int'(bus.pct_dout), 0);
    checkOutput("t5RstSig", int'(bus.pct_dout_sig_flag), 0);
    checkOutput("t5RstRate", int'(bus.pct_dout_rate_con), 11);
    checkOutput("t5RstDinRdy", int'(bus.pct_din_rdy), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.pct_din = 2'b10;
    bus.pct_din_vld = 1'b1;
    @(posedge clk); #1;
    bus.pct_din_vld = 1'b0;
    @(negedge clk);
    checkOutput("t5PostA", int'(bus.pct_dout), 0);
    checkOutput("t5PostVldA", int'(bus.pct_dout_vld), 1);
    checkOutput("t5PostRate", int'(bus.pct_dout_rate_con), 15);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t5PostB", int'(bus.pct_dout), 1);
    checkOutput("t5PostVldB", int'(bus.pct_dout_vld), 1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t5PostEnd", int'(bus.pct_dout_vld), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
